// File: rtl/cdb_arbiter_pkg.sv
// Shared constants, requester identifiers and helpers for the CDB arbiter.
package cdb_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;
  localparam int NREQ   = 4;

  typedef enum logic [1:0] {
    FU_ADD = 2'd0,
    FU_MUL = 2'd1,
    FU_LD  = 2'd2,
    FU_BCH = 2'd3
  } fu_e;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Successor of idx among n slots, wrapping from n-1 back to 0.
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester handshake and common-data-bus broadcast signals.
// master: the functional units / ROB side; slave: the arbiter.
interface cdb_arbiter_if #(
  parameter int NREQ   = cdb_arbiter_pkg::NREQ,
  parameter int DATA_W = cdb_arbiter_pkg::DATA_W,
  parameter int TAG_W  = cdb_arbiter_pkg::TAG_W
);
  import cdb_arbiter_pkg::*;

  localparam int SRC_W = src_width(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*TAG_W-1:0]  req_tag;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   cdb_stall;
  logic                   flush;
  logic                   cdb_valid;
  logic [TAG_W-1:0]       cdb_tag;
  logic [DATA_W-1:0]      cdb_data;
  logic [SRC_W-1:0]       cdb_src;

  modport master (
    output req_valid, req_tag, req_data, cdb_stall, flush,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    input  req_valid, req_tag, req_data, cdb_stall, flush,
    output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first valid slot at or after ptr,
// scanning upward modulo N. Returns a one-hot grant, its index and a hit flag.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk the slots starting at ptr and latch onto the first valid one.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && valid[(int'(ptr) + k) % N]) begin
        any   = 1'b1;
        idx   = IDX_W'((int'(ptr) + k) % N);
        grant[(int'(ptr) + k) % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: picks one completed functional-unit result per
// cycle and broadcasts its ROB tag and value one cycle later.
// Compile-time option: define CDB_FIXED_PRIO_EN for fixed lowest-index-wins
// priority; left undefined, grants rotate round-robin.
module cdb_arbiter #(
  parameter int NREQ   = cdb_arbiter_pkg::NREQ,
  parameter int DATA_W = cdb_arbiter_pkg::DATA_W,
  parameter int TAG_W  = cdb_arbiter_pkg::TAG_W
) (
  input logic          clk1,
  input logic          rst_n,
  cdb_arbiter_if.slave bus
);
  import cdb_arbiter_pkg::*;

  localparam int SRC_W = src_width(NREQ);

  logic [NREQ-1:0]   grant;
  logic [SRC_W-1:0]  win_idx;
  logic              win_any;
  logic [SRC_W-1:0]  ptr_cur;
  logic              grant_en;
  logic              xfer;

  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [SRC_W-1:0]  cdb_src_q;

`ifdef CDB_FIXED_PRIO_EN
  assign ptr_cur = '0;
`else
  logic [SRC_W-1:0] rr_ptr;

  assign ptr_cur = rr_ptr;

  // Rotate the priority pointer to just past the last winner.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= SRC_W'(next_index(int'(win_idx), NREQ));
    end
  end
`endif

  rr_picker #(
    .N     (NREQ),
    .IDX_W (SRC_W)
  ) u_picker (
    .valid (bus.req_valid),
    .ptr   (ptr_cur),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Grants are suppressed in reset, while the bus is stalled, and on a squash.
  always_comb begin
    grant_en      = rst_n && !bus.cdb_stall && !bus.flush;
    bus.req_ready = grant_en ? grant : '0;
    xfer          = grant_en && win_any;
  end

  // Broadcast register: flush beats stall, stall freezes, otherwise load the winner.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else if (bus.flush) begin
      cdb_valid_q <= 1'b0;
    end else if (bus.cdb_stall) begin
      cdb_valid_q <= cdb_valid_q;
    end else if (xfer) begin
      cdb_valid_q <= 1'b1;
      cdb_tag_q   <= bus.req_tag[int'(win_idx)*TAG_W +: TAG_W];
      cdb_data_q  <= bus.req_data[int'(win_idx)*DATA_W +: DATA_W];
      cdb_src_q   <= win_idx;
    end else begin
      cdb_valid_q <= 1'b0;
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed, table-driven bench for cdb_arbiter. Each vector is one clock:
// inputs are driven on the falling edge, req_ready is checked just after,
// and the broadcast outputs are checked just after the next rising edge.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  typedef struct {
    string      name;
    logic       rst_n;
    logic [3:0] valid;
    logic       stall;
    logic       flush;
    logic [3:0] exp_ready;
    logic       exp_cv;
    logic       chk_pay;
    logic [2:0] exp_tag;
    logic [15:0] exp_data;
    logic [1:0] exp_src;
  } vec_t;

  logic clk1;
  logic rst_n;
  logic [2:0]  tags  [4];
  logic [15:0] datas [4];
  int checks;
  int errors;
  vec_t tbl [$];

  cdb_arbiter_if #(.NREQ(4), .DATA_W(16), .TAG_W(3)) bus ();

  cdb_arbiter #(.NREQ(4), .DATA_W(16), .TAG_W(3)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  function automatic vec_t mk(string n, logic r, logic [3:0] v, logic s, logic f,
                              logic [3:0] rdy, logic cv, logic pay,
                              logic [2:0] t, logic [15:0] d, logic [1:0] src);
    vec_t x;
    x.name = n; x.rst_n = r; x.valid = v; x.stall = s; x.flush = f;
    x.exp_ready = rdy; x.exp_cv = cv; x.chk_pay = pay;
    x.exp_tag = t; x.exp_data = d; x.exp_src = src;
    return x;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    @(negedge clk1);
    rst_n         = v.rst_n;
    bus.req_valid = v.valid;
    bus.cdb_stall = v.stall;
    bus.flush     = v.flush;
    for (int i = 0; i < 4; i++) begin
      bus.req_tag[i*3 +: 3]   = tags[i];
      bus.req_data[i*16 +: 16] = datas[i];
    end
    #1;
    checkOutput({v.name, ".ready"}, 32'(bus.req_ready), 32'(v.exp_ready));
    @(posedge clk1);
    #1;
    checkOutput({v.name, ".cdb_valid"}, 32'(bus.cdb_valid), 32'(v.exp_cv));
    if (v.chk_pay) begin
      checkOutput({v.name, ".cdb_tag"},  32'(bus.cdb_tag),  32'(v.exp_tag));
      checkOutput({v.name, ".cdb_data"}, 32'(bus.cdb_data), 32'(v.exp_data));
      checkOutput({v.name, ".cdb_src"},  32'(bus.cdb_src),  32'(v.exp_src));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_tag   = '0;
    bus.req_data  = '0;
    bus.cdb_stall = 1'b0;
    bus.flush     = 1'b0;
    tags[FU_ADD] = 3'd1; datas[FU_ADD] = 16'h1111;
    tags[FU_MUL] = 3'd3; datas[FU_MUL] = 16'h2222;
    tags[FU_LD]  = 3'd5; datas[FU_LD]  = 16'h00AB;
    tags[FU_BCH] = 3'd7; datas[FU_BCH] = 16'h4444;

`ifdef CDB_FIXED_PRIO_EN
    tbl.push_back(mk("rst",    0, 4'b1110, 0, 0, 4'b0000, 0, 1, 3'd0, 16'h0000, 2'd0));
    tbl.push_back(mk("fix1",   1, 4'b1110, 0, 0, 4'b0010, 1, 1, 3'd3, 16'h2222, 2'd1));
    tbl.push_back(mk("fix2",   1, 4'b1110, 0, 0, 4'b0010, 1, 1, 3'd3, 16'h2222, 2'd1));
    tbl.push_back(mk("fix3",   1, 4'b1110, 0, 0, 4'b0010, 1, 1, 3'd3, 16'h2222, 2'd1));
    tbl.push_back(mk("fix_hi", 1, 4'b1000, 0, 0, 4'b1000, 1, 1, 3'd7, 16'h4444, 2'd3));
    tbl.push_back(mk("fix_lo", 1, 4'b1111, 0, 0, 4'b0001, 1, 1, 3'd1, 16'h1111, 2'd0));
    foreach (tbl[i]) applyStimulus(tbl[i]);
`else
    // reset, single request, then all-valid rotation and wrap patterns
    tbl.push_back(mk("rst0",    0, 4'b1111, 0, 0, 4'b0000, 0, 1, 3'd0, 16'h0000, 2'd0));
    tbl.push_back(mk("rst1",    0, 4'b0000, 0, 0, 4'b0000, 0, 1, 3'd0, 16'h0000, 2'd0));
    tbl.push_back(mk("single",  1, 4'b0100, 0, 0, 4'b0100, 1, 1, 3'd5, 16'h00AB, 2'd2));
    tbl.push_back(mk("idle",    1, 4'b0000, 0, 0, 4'b0000, 0, 0, 3'd0, 16'h0000, 2'd0));
    tbl.push_back(mk("rst2",    0, 4'b1111, 0, 0, 4'b0000, 0, 1, 3'd0, 16'h0000, 2'd0));
    tbl.push_back(mk("all_g0",  1, 4'b1111, 0, 0, 4'b0001, 1, 1, 3'd1, 16'h1111, 2'd0));
    tbl.push_back(mk("all_g1",  1, 4'b1111, 0, 0, 4'b0010, 1, 1, 3'd3, 16'h2222, 2'd1));
    tbl.push_back(mk("all_g2",  1, 4'b1111, 0, 0, 4'b0100, 1, 1, 3'd5, 16'h00AB, 2'd2));
    tbl.push_back(mk("all_g3",  1, 4'b1111, 0, 0, 4'b1000, 1, 1, 3'd7, 16'h4444, 2'd3));
    tbl.push_back(mk("all_g0b", 1, 4'b1111, 0, 0, 4'b0001, 1, 1, 3'd1, 16'h1111, 2'd0));
    tbl.push_back(mk("odd_a",   1, 4'b1010, 0, 0, 4'b0010, 1, 1, 3'd3, 16'h2222, 2'd1));
    tbl.push_back(mk("odd_b",   1, 4'b1010, 0, 0, 4'b1000, 1, 1, 3'd7, 16'h4444, 2'd3));
    tbl.push_back(mk("odd_wrap",1, 4'b1010, 0, 0, 4'b0010, 1, 1, 3'd3, 16'h2222, 2'd1));
    tbl.push_back(mk("idle2",   1, 4'b0000, 0, 0, 4'b0000, 0, 0, 3'd0, 16'h0000, 2'd0));
    tbl.push_back(mk("ptr_kept",1, 4'b0011, 0, 0, 4'b0001, 1, 1, 3'd1, 16'h1111, 2'd0));
    foreach (tbl[i]) applyStimulus(tbl[i]);

    // stall: tag 3 broadcast held for three stalled cycles, then requester 1 again
    applyStimulus(mk("st_pre",  1, 4'b0010, 0, 0, 4'b0010, 1, 1, 3'd3, 16'h2222, 2'd1));
    tags[FU_MUL] = 3'd2; datas[FU_MUL] = 16'h2BBB;
    for (int i = 0; i < 3; i++)
      applyStimulus(mk("st_hold", 1, 4'b0010, 1, 0, 4'b0000, 1, 1, 3'd3, 16'h2222, 2'd1));
    applyStimulus(mk("st_rel",  1, 4'b0010, 0, 0, 4'b0010, 1, 1, 3'd2, 16'h2BBB, 2'd1));

    // flush while broadcasting: no grant, valid drops, pointer keeps its place
    applyStimulus(mk("fl_sq",   1, 4'b1001, 0, 1, 4'b0000, 0, 0, 3'd0, 16'h0000, 2'd0));
    applyStimulus(mk("fl_next", 1, 4'b1001, 0, 0, 4'b1000, 1, 1, 3'd7, 16'h4444, 2'd3));
    applyStimulus(mk("fl_stall",1, 4'b1001, 1, 1, 4'b0000, 0, 0, 3'd0, 16'h0000, 2'd0));
    applyStimulus(mk("fl_after",1, 4'b1001, 0, 0, 4'b0001, 1, 1, 3'd1, 16'h1111, 2'd0));

    // reset during a broadcast with everyone requesting
    applyStimulus(mk("mid_rst", 0, 4'b1111, 0, 0, 4'b0000, 0, 1, 3'd0, 16'h0000, 2'd0));
    applyStimulus(mk("post_rst",1, 4'b1111, 0, 0, 4'b0001, 1, 1, 3'd1, 16'h1111, 2'd0));
    applyStimulus(mk("post_r1", 1, 4'b1111, 0, 0, 4'b0010, 1, 1, 3'd2, 16'h2BBB, 2'd1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
